stream_tx_framer: RTL

- Consumer-side counterpart of the header/payload stream FIFO.
- Pulls beats from an in_reg-style source and re-frames them into a registered axis-like master stream.
- Holds the packet header (tuser) constant across each packet and enforces tstart/tlast framing.
- Runs at full throughput through a 2-entry skid stage, and counts dropped, errored and completed packets.

---
 rtl/stream_skid_reg.sv | 48 ++++
 rtl/stream_tx_framer.sv | 112 +++++++++++
 2 files changed

// File: rtl/stream_skid_reg.sv
// Two-entry valid/ready register slice: an output register plus one skid entry.
// in_ready is derived only from registered state, which breaks the combinational path from out_ready.
module stream_skid_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    assign in_ready = !skid_valid;

    // When the output register is free, the skid entry drains ahead of any new beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= in_valid;
                if (in_valid) begin
                    skid_data <= in_data;
                end
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    out_data <= in_data;
                end
            end
        end else if (in_valid && !skid_valid) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end

endmodule

// File: rtl/stream_tx_framer.sv
// Re-frames beats from an in_reg-style source into a registered axis-like stream.
// The header is held across each packet, framing is enforced, and drops/errors/packets are counted.
module stream_tx_framer #(
    parameter int TUSER_WIDTH       = 128,
    parameter int TDATA_WIDTH       = 256,
    parameter int TKEEP_WIDTH       = TDATA_WIDTH / 8,
    parameter int MAX_BEATS         = 64,
    parameter int ZERO_KEEP_AS_FULL = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_reg_tvalid,
    input  logic                   in_reg_tlast,
    input  logic                   in_reg_tstart,
    input  logic [TUSER_WIDTH-1:0] in_reg_tuser,
    input  logic [TDATA_WIDTH-1:0] in_reg_tdata,
    input  logic [TKEEP_WIDTH-1:0] in_reg_tkeep,
    output logic                   in_reg_tready,
    output logic                   axis_tvalid,
    output logic                   axis_tlast,
    output logic                   axis_tstart,
    output logic [TUSER_WIDTH-1:0] axis_tuser,
    output logic [TDATA_WIDTH-1:0] axis_tdata,
    output logic [TKEEP_WIDTH-1:0] axis_tkeep,
    input  logic                   axis_tready,
    output logic [15:0]            drop_cnt,
    output logic [15:0]            err_cnt,
    output logic [15:0]            pkt_cnt
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);
    localparam int PAY_W = 2 + TKEEP_WIDTH + TUSER_WIDTH + TDATA_WIDTH;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    state_t                 state;
    logic [TUSER_WIDTH-1:0] hdr;
    logic [CNT_W-1:0]       beat_cnt;
    logic [CNT_W-1:0]       next_cnt;
    logic                   accept;
    logic                   fwd;
    logic                   drop;
    logic                   restart;
    logic                   force_end;
    logic                   fwd_last;
    logic                   skid_ready;
    logic [TUSER_WIDTH-1:0] fwd_user;
    logic [TKEEP_WIDTH-1:0] fwd_keep;
    logic [PAY_W-1:0]       fwd_payload;
    logic [PAY_W-1:0]       out_payload;

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic inc);
        return (inc && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
    endfunction

    assign in_reg_tready = !rst && skid_ready;

    // A tstart beat always opens a packet; plain beats only count while inside one.
    always_comb begin
        accept    = in_reg_tvalid && in_reg_tready;
        fwd       = accept && (in_reg_tstart || state == IN_PKT);
        drop      = accept && !in_reg_tstart && state == IDLE;
        restart   = accept && in_reg_tstart && state == IN_PKT;
        next_cnt  = in_reg_tstart ? CNT_W'(1) : beat_cnt + CNT_W'(1);
        force_end = fwd && !in_reg_tlast && next_cnt == CNT_W'(MAX_BEATS);
        fwd_last  = in_reg_tlast || force_end;
        fwd_user  = in_reg_tstart ? in_reg_tuser : hdr;
        fwd_keep  = (ZERO_KEEP_AS_FULL != 0 && in_reg_tkeep == '0) ? '1 : in_reg_tkeep;
        fwd_payload = {in_reg_tstart, fwd_last, fwd_keep, fwd_user, in_reg_tdata};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hdr      <= '0;
            beat_cnt <= '0;
            drop_cnt <= '0;
            err_cnt  <= '0;
            pkt_cnt  <= '0;
        end else begin
            if (fwd) begin
                beat_cnt <= next_cnt;
                state    <= fwd_last ? IDLE : IN_PKT;
                if (in_reg_tstart) begin
                    hdr <= in_reg_tuser;
                end
            end
            drop_cnt <= sat_inc(drop_cnt, drop);
            err_cnt  <= sat_inc(err_cnt, restart || force_end);
            pkt_cnt  <= sat_inc(pkt_cnt, fwd && fwd_last);
        end
    end

    stream_skid_reg #(
        .WIDTH(PAY_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (fwd),
        .in_data  (fwd_payload),
        .in_ready (skid_ready),
        .out_valid(axis_tvalid),
        .out_data (out_payload),
        .out_ready(axis_tready)
    );

    assign {axis_tstart, axis_tlast, axis_tkeep, axis_tuser, axis_tdata} = out_payload;

endmodule
